// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259A-style interrupt acknowledge path.
// Holds the IR level constants, the acknowledge FSM state type and the priority encoder.
package pic_pkg;

    localparam int NUM_IR = 8;
    localparam int LVL_W  = 3;

    localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT1 = 3'd1,
        HOLD1 = 3'd2,
        WAIT2 = 3'd3,
        DRIVE = 3'd4
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [LVL_W-1:0] idx;
    } prio_t;

    // Lowest set index wins: IR0 is the highest priority level.
    function automatic prio_t prio_enc(input logic [NUM_IR-1:0] vec);
        prio_t res;
        res.valid = 1'b0;
        res.idx   = '0;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res.valid = 1'b1;
                res.idx   = LVL_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Fixed-priority resolution of the masked request set against the in-service register.
// A request qualifies only when it outranks every level currently in service.
module pic_prio_resolver
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] pending,
    input  logic [NUM_IR-1:0] isr,
    output logic              qualify,
    output logic [LVL_W-1:0]  cand
);

    prio_t pend_p;
    prio_t isr_p;

    always_comb begin
        pend_p  = prio_enc(pending);
        isr_p   = prio_enc(isr);
        cand    = pend_p.idx;
        qualify = pend_p.valid && (!isr_p.valid || (pend_p.idx < isr_p.idx));
    end

endmodule

// File: rtl/inta_responder.sv
// CPU-facing end of the interrupt controller: raises INT, runs the two-pulse INTA
// handshake, drives the vector on the second pulse and owns the in-service register.
module inta_responder
    import pic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IR-1:0] irr,
    input  logic [NUM_IR-1:0] imr_output,
    input  logic              inta_n,
    input  logic              eoi_ns,
    input  logic              eoi_sp,
    input  logic [LVL_W-1:0]  eoi_level,
    input  logic              aeoi,
    input  logic [4:0]        vector_base,
    output logic              int_out,
    output logic [NUM_IR-1:0] irr_clear,
    output logic [NUM_IR-1:0] isr,
    output logic [7:0]        vector_out,
    output logic              data_drive
);

    state_e            state_q, state_d;
    logic              inta_q;
    logic              int_out_q, int_out_d;
    logic [NUM_IR-1:0] irr_clear_q, irr_clear_d;
    logic [NUM_IR-1:0] isr_q, isr_d;
    logic [7:0]        vector_out_q, vector_out_d;
    logic              data_drive_q, data_drive_d;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic              spurious_q, spurious_d;

    logic              qualify;
    logic [LVL_W-1:0]  cand;
    logic              inta_fall;
    logic              inta_rise;
    logic [NUM_IR-1:0] set_vec;
    logic [NUM_IR-1:0] aeoi_clr;
    logic [NUM_IR-1:0] eoi_clr;
    prio_t             isr_p;

    pic_prio_resolver u_prio (
        .pending (irr & ~imr_output),
        .isr     (isr_q),
        .qualify (qualify),
        .cand    (cand)
    );

    assign inta_fall = inta_q & ~inta_n;
    assign inta_rise = ~inta_q & inta_n;

    always_comb begin
        state_d      = state_q;
        int_out_d    = int_out_q;
        lvl_d        = lvl_q;
        spurious_d   = spurious_q;
        vector_out_d = vector_out_q;
        data_drive_d = data_drive_q;
        set_vec      = '0;
        aeoi_clr     = '0;
        eoi_clr      = '0;
        isr_p        = prio_enc(isr_q);

        case (state_q)
            IDLE: begin
                if (qualify) begin
                    state_d   = WAIT1;
                    int_out_d = 1'b1;
                end
            end
            WAIT1: begin
                // The INTA edge is checked first so a mask landing with it yields a spurious ack.
                if (inta_fall) begin
                    int_out_d = 1'b0;
                    state_d   = HOLD1;
                    if (qualify) begin
                        lvl_d         = cand;
                        spurious_d    = 1'b0;
                        set_vec[cand] = 1'b1;
                    end else begin
                        lvl_d      = SPURIOUS_LVL;
                        spurious_d = 1'b1;
                    end
                end else if (!qualify) begin
                    int_out_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            HOLD1: begin
                if (inta_rise) begin
                    state_d = WAIT2;
                end
            end
            WAIT2: begin
                if (inta_fall) begin
                    state_d      = DRIVE;
                    vector_out_d = {vector_base, lvl_q};
                    data_drive_d = 1'b1;
                end
            end
            DRIVE: begin
                if (inta_rise) begin
                    state_d      = IDLE;
                    vector_out_d = '0;
                    data_drive_d = 1'b0;
                    if (aeoi && !spurious_q) begin
                        aeoi_clr[lvl_q] = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (eoi_sp) begin
            eoi_clr[eoi_level] = 1'b1;
        end else if (eoi_ns && isr_p.valid) begin
            eoi_clr[isr_p.idx] = 1'b1;
        end

        irr_clear_d = set_vec;
        isr_d       = (isr_q & ~eoi_clr & ~aeoi_clr) | set_vec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            inta_q       <= 1'b1;
            int_out_q    <= 1'b0;
            irr_clear_q  <= '0;
            isr_q        <= '0;
            vector_out_q <= '0;
            data_drive_q <= 1'b0;
            lvl_q        <= '0;
            spurious_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            inta_q       <= inta_n;
            int_out_q    <= int_out_d;
            irr_clear_q  <= irr_clear_d;
            isr_q        <= isr_d;
            vector_out_q <= vector_out_d;
            data_drive_q <= data_drive_d;
            lvl_q        <= lvl_d;
            spurious_q   <= spurious_d;
        end
    end

    assign int_out    = int_out_q;
    assign irr_clear  = irr_clear_q;
    assign isr        = isr_q;
    assign vector_out = vector_out_q;
    assign data_drive = data_drive_q;

endmodule

// File: tb/tb_inta_responder.sv
// Bench for inta_responder: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model of the acknowledge protocol.
module tb_inta_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irr;
    logic [7:0] imr_output;
    logic       inta_n;
    logic       eoi_ns;
    logic       eoi_sp;
    logic [2:0] eoi_level;
    logic       aeoi;
    logic [4:0] vector_base;
    logic       int_out;
    logic [7:0] irr_clear;
    logic [7:0] isr;
    logic [7:0] vector_out;
    logic       data_drive;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    inta_responder dut (
        .clk         (clk),
        .rst         (rst),
        .irr         (irr),
        .imr_output  (imr_output),
        .inta_n      (inta_n),
        .eoi_ns      (eoi_ns),
        .eoi_sp      (eoi_sp),
        .eoi_level   (eoi_level),
        .aeoi        (aeoi),
        .vector_base (vector_base),
        .int_out     (int_out),
        .irr_clear   (irr_clear),
        .isr         (isr),
        .vector_out  (vector_out),
        .data_drive  (data_drive)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lowest set bit index, 8 meaning "none" so it ranks below every real level.
    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 8;
    endfunction

    // Reference model: a sequence is "open" from INT assertion; m_edges counts INTA
    // transitions consumed (fall, rise, fall, rise) and closes it on the fourth.
    bit         m_open = 1'b0;
    int         m_edges = 0;
    int         m_lvl = 0;
    bit         m_spur = 1'b0;
    logic [7:0] m_isr = '0;
    logic [7:0] m_irr_clear = '0;
    bit         m_prev_inta = 1'b1;
    bit         m_int_out = 1'b0;
    bit         m_dd = 1'b0;
    logic [7:0] m_drive_vec = '0;
    logic [7:0] m_vec = '0;
    logic [7:0] exp_q[$];

    always @(posedge clk) begin
        logic [7:0] pend;
        logic [7:0] set_m;
        logic [7:0] clr_m;
        int cand;
        int cur;
        bit qual;
        bit fall;
        bit rise;
        pend  = irr & ~imr_output;
        cand  = lowest(pend);
        cur   = lowest(m_isr);
        qual  = (pend != 8'h00) && (cand < cur);
        fall  = m_prev_inta && !inta_n;
        rise  = !m_prev_inta && inta_n;
        set_m = '0;
        clr_m = '0;
        if (rst) begin
            m_open      = 1'b0;
            m_edges     = 0;
            m_lvl       = 0;
            m_spur      = 1'b0;
            m_isr       = '0;
            m_prev_inta = 1'b1;
            exp_q.delete();
        end else begin
            if (!m_open) begin
                if (qual) begin
                    m_open  = 1'b1;
                    m_edges = 0;
                end
            end else if (m_edges == 0) begin
                if (fall) begin
                    m_edges = 1;
                    if (qual) begin
                        m_lvl       = cand;
                        m_spur      = 1'b0;
                        set_m[cand] = 1'b1;
                    end else begin
                        m_lvl  = 7;
                        m_spur = 1'b1;
                    end
                end else if (!qual) begin
                    m_open = 1'b0;
                end
            end else if (m_edges == 1) begin
                if (rise) m_edges = 2;
            end else if (m_edges == 2) begin
                if (fall) begin
                    m_edges     = 3;
                    m_drive_vec = {vector_base, 3'(m_lvl)};
                    exp_q.push_back(m_drive_vec);
                end
            end else if (rise) begin
                m_open = 1'b0;
                if (aeoi && !m_spur) clr_m[m_lvl] = 1'b1;
            end
            if (eoi_sp) clr_m[eoi_level] = 1'b1;
            else if (eoi_ns && cur < 8) clr_m[cur] = 1'b1;
            m_isr       = (m_isr & ~clr_m) | set_m;
            m_prev_inta = inta_n;
        end
        m_irr_clear = set_m;
        m_int_out   = m_open && (m_edges == 0);
        m_dd        = m_open && (m_edges == 3);
        m_vec       = m_dd ? m_drive_vec : 8'h00;
    end

    logic dd_prev = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("int_out", {7'b0, int_out}, {7'b0, m_int_out});
            chk("irr_clear", irr_clear, m_irr_clear);
            chk("isr", isr, m_isr);
            chk("vector_out", vector_out, m_vec);
            chk("data_drive", {7'b0, data_drive}, {7'b0, m_dd});
            if (data_drive && !dd_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL vector_sb: got unexpected drive %h expected none", vector_out);
                end else begin
                    chk("vector_sb", vector_out, exp_q.pop_front());
                end
            end
            dd_prev = data_drive;
        end
    end

    task automatic ack(output logic [7:0] vec);
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        vec = vector_out;
        inta_n = 1'b1; tick();
    endtask

    initial begin
        logic [7:0] vec;
        int cpu_len;
        int cpu_edges;
        rst = 1'b1; irr = '0; imr_output = '0; inta_n = 1'b1;
        eoi_ns = 1'b0; eoi_sp = 1'b0; eoi_level = '0; aeoi = 1'b0;
        vector_base = 5'b01000;
        tick();
        cmp_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_int_out", {7'b0, int_out}, 8'h00);
        chk("rst_isr", isr, 8'h00);
        chk("rst_vector", vector_out, 8'h00);
        chk("rst_drive", {7'b0, data_drive}, 8'h00);

        // Basic acknowledge of IR3
        irr = 8'h08; tick();
        chk("basic_int", {7'b0, int_out}, 8'h01);
        inta_n = 1'b0; tick();
        chk("basic_irr_clear", irr_clear, 8'h08);
        chk("basic_isr", isr, 8'h08);
        chk("basic_int_drop", {7'b0, int_out}, 8'h00);
        irr = 8'h00; tick();
        chk("basic_irr_clear_end", irr_clear, 8'h00);
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        chk("basic_vector", vector_out, 8'h43);
        chk("basic_drive", {7'b0, data_drive}, 8'h01);
        tick();
        inta_n = 1'b1; tick();
        chk("basic_drive_off", {7'b0, data_drive}, 8'h00);
        chk("basic_vector_off", vector_out, 8'h00);
        eoi_ns = 1'b1; tick(); eoi_ns = 1'b0;
        chk("basic_eoi", isr, 8'h00);

        // INTA falling edge while idle is ignored
        inta_n = 1'b0; tick(); tick();
        chk("idle_inta_drive", {7'b0, data_drive}, 8'h00);
        inta_n = 1'b1; tick();

        // Priority and nesting
        irr = 8'h08; tick(); ack(vec); irr = 8'h00;
        irr = 8'h20; tick(); tick(); tick();
        chk("nest_low_blocked", {7'b0, int_out}, 8'h00);
        irr = 8'h22; tick();
        chk("nest_high_int", {7'b0, int_out}, 8'h01);
        ack(vec);
        chk("nest_vector", vec, 8'h41);
        chk("nest_isr", isr, 8'h0A);
        irr = 8'h00;
        eoi_ns = 1'b1; tick(); tick(); eoi_ns = 1'b0;
        chk("nest_eoi", isr, 8'h00);

        // Mask arriving with the first INTA gives a spurious vector
        irr = 8'h04; tick();
        chk("spur_int", {7'b0, int_out}, 8'h01);
        imr_output = 8'h04; inta_n = 1'b0; tick();
        chk("spur_isr", isr, 8'h00);
        chk("spur_irr_clear", irr_clear, 8'h00);
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        chk("spur_vector", vector_out, 8'h47);
        inta_n = 1'b1; tick();
        imr_output = 8'h00; tick();
        chk("mask_int_up", {7'b0, int_out}, 8'h01);
        imr_output = 8'h04; tick();
        chk("mask_int_drop", {7'b0, int_out}, 8'h00);
        irr = 8'h00; imr_output = 8'h00; tick();

        // Automatic EOI
        aeoi = 1'b1; irr = 8'h01; tick();
        inta_n = 1'b0; tick();
        chk("aeoi_set", isr, 8'h01);
        irr = 8'h00;
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        chk("aeoi_hold", isr, 8'h01);
        inta_n = 1'b1; tick();
        chk("aeoi_clear", isr, 8'h00);
        aeoi = 1'b0;

        // Specific EOI precedence and set-beats-clear
        irr = 8'h10; tick(); ack(vec); irr = 8'h00;
        irr = 8'h01; tick(); ack(vec); irr = 8'h00;
        chk("eoi_isr11", isr, 8'h11);
        eoi_sp = 1'b1; eoi_level = 3'd4; eoi_ns = 1'b1; tick();
        eoi_sp = 1'b0; eoi_ns = 1'b0;
        chk("eoi_sp_prec", isr, 8'h01);
        eoi_ns = 1'b1; tick(); eoi_ns = 1'b0;
        irr = 8'h01; tick();
        inta_n = 1'b0; eoi_sp = 1'b1; eoi_level = 3'd0; tick();
        eoi_sp = 1'b0;
        chk("set_wins", isr, 8'h01);
        irr = 8'h00;
        inta_n = 1'b1; tick(); inta_n = 1'b0; tick(); inta_n = 1'b1; tick();
        eoi_ns = 1'b1; tick(); eoi_ns = 1'b0;

        // Reset in the middle of the vector drive
        irr = 8'h08; tick();
        inta_n = 1'b0; tick(); inta_n = 1'b1; tick(); inta_n = 1'b0; tick();
        chk("mid_drive", {7'b0, data_drive}, 8'h01);
        rst = 1'b1; inta_n = 1'b1; tick();
        chk("mid_rst_drive", {7'b0, data_drive}, 8'h00);
        chk("mid_rst_vector", vector_out, 8'h00);
        chk("mid_rst_isr", isr, 8'h00);
        chk("mid_rst_int", {7'b0, int_out}, 8'h00);
        rst = 1'b0; tick();
        chk("mid_rst_reraise", {7'b0, int_out}, 8'h01);

        // Random traffic against the model
        cpu_len = 0;
        cpu_edges = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            irr = irr & ~m_irr_clear;
            if ($urandom_range(0, 7) == 0) irr = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 15) == 0) imr_output = 8'($urandom) & 8'($urandom) & 8'($urandom);
            eoi_ns    = ($urandom_range(0, 19) == 0);
            eoi_sp    = ($urandom_range(0, 24) == 0);
            eoi_level = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 63) == 0) aeoi = ~aeoi;
            if (cpu_len > 0) begin
                cpu_len--;
            end else if (cpu_edges > 0) begin
                inta_n = ~inta_n;
                cpu_edges--;
                cpu_len = $urandom_range(0, 2);
            end else if ((m_int_out && $urandom_range(0, 2) == 0) || $urandom_range(0, 49) == 0) begin
                inta_n = 1'b0;
                cpu_edges = 3;
                cpu_len = $urandom_range(0, 2);
            end
            rst = ($urandom_range(0, 399) == 0);
            if (rst) begin
                inta_n = 1'b1;
                cpu_edges = 0;
                cpu_len = 0;
            end
            tick();
        end
        rst = 1'b0; eoi_ns = 1'b0; eoi_sp = 1'b0; inta_n = 1'b1;
        tick(); tick();
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
